// File: rtl/fmark_conditioner_if.sv
// fmark_conditioner_if
//   Bundles the FMARK conditioner's pad input, clear input and status outputs.
//   The conditioner has no valid/ready handshake. fmark_pulse is a single-cycle
//   strobe. period/period_vld/timeout are level status that can be read in any cycle.
//   Modports:
//     slave  - conditioner side (takes pad/clr, drives status)
//     master - consumer/driver side (drives pad/clr, reads status)
//   Signals:
//     fmark_pad   raw FMARK pad level (asynchronous to clk)
//     clr         synchronous clear of measurement state
//     fmark_pulse one-cycle pulse per qualified rising edge
//     fmark_level filtered FMARK level
//     period      clk cycles between last two qualified pulses
//     period_vld  period holds a valid measurement
//     timeout     no qualified pulse for 2^TIMEOUT_W-1 cycles
//     state_dbg   measurement FSM state (debug visibility)
interface fmark_conditioner_if #(
    parameter int TIMEOUT_W = 24
);
    logic                 fmark_pad;
    logic                 clr;
    logic                 fmark_pulse;
    logic                 fmark_level;
    logic [TIMEOUT_W-1:0] period;
    logic                 period_vld;
    logic                 timeout;
    logic [1:0]           state_dbg;

    modport slave (
        input  fmark_pad, clr,
        output fmark_pulse, fmark_level, period, period_vld, timeout, state_dbg
    );

    modport master (
        output fmark_pad, clr,
        input  fmark_pulse, fmark_level, period, period_vld, timeout, state_dbg
    );
endinterface

// File: rtl/fmark_conditioner.sv
// fmark_conditioner
//   Conditions the raw LCD FMARK (tearing-effect) pad. The pad goes through a
//   2-flop synchroniser and an optional glitch filter. The block then emits a
//   one-cycle pulse on each qualified rising edge, which feeds lcd_fmark. It also
//   measures the frame period and flags loss of FMARK.
//   Build option: FMARK_FILTER_EN
//     defined   - a new level must persist FILT_LEN cycles at the synchroniser
//                 output before it is accepted (pulse latency FILT_LEN+2).
//     undefined - no filter; the synchronised level is taken directly
//                 (pulse latency 3).
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset
//     bus  fmark_conditioner_if.slave (pad, clr, status outputs, state debug)
module fmark_conditioner #(
    parameter int FILT_LEN  = 4,
    parameter int TIMEOUT_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    fmark_conditioner_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2,
        LOST  = 2'd3
    } state_t;

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    if (FILT_LEN < 1) begin : g_bad_filt_len
        $error("fmark_conditioner: FILT_LEN must be >= 1");
    end

    logic                 s1, s2;
    logic                 fmark_level, level_nxt;
    logic                 fmark_pulse;
    logic [TIMEOUT_W-1:0] cnt;
    logic                 cnt_sat;
    logic [TIMEOUT_W-1:0] period, period_nxt;
    logic                 period_vld, period_vld_nxt;
    logic                 timeout, timeout_nxt;
    state_t               state, state_nxt;

    // Synchroniser for the asynchronous pad.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.fmark_pad;
            s2 <= s1;
        end
    end

`ifdef FMARK_FILTER_EN
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] FILT_LAST = CW'(FILT_LEN - 1);

    logic [CW-1:0] filt_cnt, filt_cnt_nxt;

    // Count how long s2 has disagreed with the accepted level. Any agreement
    // restarts the count, so a deviation shorter than FILT_LEN cycles is dropped.
    always_comb begin
        level_nxt    = fmark_level;
        filt_cnt_nxt = '0;
        if (s2 != fmark_level) begin
            if (filt_cnt == FILT_LAST) begin
                level_nxt = s2;
            end else begin
                filt_cnt_nxt = filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt_nxt;
        end
    end
`else
    always_comb begin
        level_nxt = s2;
    end
`endif

    // The pulse is registered alongside the level, so it is high in exactly
    // the cycle in which fmark_level first reads 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fmark_level <= 1'b0;
            fmark_pulse <= 1'b0;
        end else begin
            fmark_level <= level_nxt;
            fmark_pulse <= level_nxt & ~fmark_level;
        end
    end

    // Period counter. It reloads to 1 on a pulse, so at the next pulse it holds
    // the exact spacing in cycles.
    assign cnt_sat = (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (bus.clr) begin
            cnt <= '0;
        end else if (fmark_pulse) begin
            cnt <= TIMEOUT_W'(1);
        end else if (!cnt_sat) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Measurement FSM. clr beats pulse, and pulse beats saturation.
    always_comb begin
        state_nxt      = state;
        period_nxt     = period;
        period_vld_nxt = period_vld;
        timeout_nxt    = timeout;
        if (bus.clr) begin
            state_nxt      = IDLE;
            period_nxt     = '0;
            period_vld_nxt = 1'b0;
            timeout_nxt    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fmark_pulse) begin
                        state_nxt = FIRST;
                    end else if (cnt_sat) begin
                        state_nxt   = LOST;
                        timeout_nxt = 1'b1;
                    end
                end
                FIRST: begin
                    if (fmark_pulse) begin
                        // A saturated count is not a real period; keep waiting.
                        if (!cnt_sat) begin
                            state_nxt      = RUN;
                            period_nxt     = cnt;
                            period_vld_nxt = 1'b1;
                        end
                    end else if (cnt_sat) begin
                        state_nxt   = LOST;
                        timeout_nxt = 1'b1;
                    end
                end
                RUN: begin
                    if (fmark_pulse) begin
                        if (!cnt_sat) begin
                            period_nxt = cnt;
                        end else begin
                            state_nxt      = FIRST;
                            period_vld_nxt = 1'b0;
                        end
                    end else if (cnt_sat) begin
                        state_nxt      = LOST;
                        period_vld_nxt = 1'b0;
                        timeout_nxt    = 1'b1;
                    end
                end
                LOST: begin
                    if (fmark_pulse) begin
                        state_nxt   = FIRST;
                        timeout_nxt = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            period     <= '0;
            period_vld <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            period     <= period_nxt;
            period_vld <= period_vld_nxt;
            timeout    <= timeout_nxt;
        end
    end

    assign bus.fmark_pulse = fmark_pulse;
    assign bus.fmark_level = fmark_level;
    assign bus.period      = period;
    assign bus.period_vld  = period_vld;
    assign bus.timeout     = timeout;
    assign bus.state_dbg   = state;
endmodule
